// File: rtl/dpram_stream_reader_pkg.sv
// Shared definitions for the dual-port RAM stream reader: controller state
// encoding and skid FIFO sizing.
package dpram_stream_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam int SKID_DEPTH = 2;
   localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/dpram_stream_reader_skid_fifo.sv
// Two-entry skid FIFO for the stream reader. The head entry drives the stream
// directly, so a push into an empty FIFO appears one cycle later.
module stream_skid_fifo
   import dpram_stream_reader_pkg::*;
#(
   parameter int WIDTH = 9
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  flush,
   input  logic                  push,
   input  logic [WIDTH-1:0]      push_data,
   input  logic                  pop,
   output logic [WIDTH-1:0]      head_data,
   output logic                  head_valid,
   output logic [SKID_CNT_W-1:0] count
);

   logic [WIDTH-1:0] slot [SKID_DEPTH];
   logic             wr_ptr;
   logic             rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign head_valid = (count != '0);
   assign head_data  = slot[rd_ptr];
   assign push_ok    = push && (count != SKID_CNT_W'(SKID_DEPTH));
   assign pop_ok     = pop && head_valid;

   // Slots reset to zero so the stream word reads as zero straight out of reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         slot[0] <= '0;
         slot[1] <= '0;
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         count   <= '0;
      end else if (flush) begin
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         count   <= '0;
      end else begin
         if (push_ok) begin
            slot[wr_ptr] <= push_data;
            wr_ptr       <= ~wr_ptr;
         end
         if (pop_ok) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + SKID_CNT_W'(1);
            2'b01:   count <= count - SKID_CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dpram_stream_reader.sv
// Bulk reader for one port of a registered-read dual-port RAM: walks LEN words
// from BASE and emits them on a valid/ready stream with a last flag.
module dpram_stream_reader
   import dpram_stream_reader_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] length,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] ram_address,
   input  logic [DATA_W-1:0] ram_q,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last
);

   state_t                  state;
   logic [ADDR_W-1:0]       len_reg;
   logic [ADDR_W-1:0]       issued;
   logic                    inflight;
   logic                    inflight_last;

   logic [DATA_W:0]         head_data;
   logic                    head_valid;
   logic [SKID_CNT_W-1:0]   fifo_count;
   logic [SKID_CNT_W:0]     occupancy;
   logic                    pop;
   logic                    flush;
   logic                    issue;
   logic                    issue_last;
   logic                    room;

   assign out_valid = head_valid;
   assign out_data  = head_data[DATA_W-1:0];
   assign out_last  = head_valid && head_data[DATA_W];

   assign pop   = head_valid && out_ready;
   assign flush = abort && (state != ST_IDLE);

   // Words held in the FIFO plus the one in the RAM pipeline never exceed the
   // FIFO depth; a pop this cycle frees one slot for the word issued now.
   assign occupancy  = {1'b0, fifo_count} + {{SKID_CNT_W{1'b0}}, inflight};
   assign room       = pop ? (occupancy <= (SKID_CNT_W + 1)'(SKID_DEPTH))
                           : (occupancy <= (SKID_CNT_W + 1)'(SKID_DEPTH - 1));
   assign issue      = (state == ST_READ) && !abort && room;
   assign issue_last = (issued == (len_reg - ADDR_W'(1)));

   stream_skid_fifo #(
      .WIDTH(DATA_W + 1)
   ) u_skid (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .push      (inflight && !flush),
      .push_data ({inflight_last, ram_q}),
      .pop       (pop),
      .head_data (head_data),
      .head_valid(head_valid),
      .count     (fifo_count)
   );

   // In-flight tracking: ram_q is valid the cycle after an issue, so the
   // issue strobe and its last tag are delayed one cycle to drive the push.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else begin
         inflight      <= issue;
         inflight_last <= issue && issue_last;
      end
   end

   // Controller: accepts commands, advances the address on each issue and
   // closes the transfer once the last-tagged word leaves the stream.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         ram_address <= '0;
         len_reg     <= '0;
         issued      <= '0;
      end else begin
         done <= 1'b0;
         if (flush) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start) begin
                     if (length == '0) begin
                        done <= 1'b1;
                     end else begin
                        state       <= ST_READ;
                        busy        <= 1'b1;
                        ram_address <= base_addr;
                        len_reg     <= length;
                        issued      <= '0;
                     end
                  end
               end
               ST_READ: begin
                  if (issue) begin
                     ram_address <= ram_address + ADDR_W'(1);
                     issued      <= issued + ADDR_W'(1);
                     if (issue_last) begin
                        state <= ST_DRAIN;
                     end
                  end
               end
               ST_DRAIN: begin
                  if (pop && out_last) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
               default: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Self-checking bench for dpram_stream_reader: 1-cycle RAM model, scoreboard
// of expected stream words, and per-scenario tasks.
module tb_dpram_stream_reader;

   logic       clk;
   logic       reset_n;
   logic       start;
   logic [9:0] base_addr;
   logic [9:0] length;
   logic       abort;
   logic       busy;
   logic       done;
   logic [9:0] ram_address;
   logic [7:0] ram_q;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_last;

   logic [7:0] mem [1024];
   logic [8:0] sb [$];
   int         checks;
   int         failures;
   int         beats;
   logic       stall_pending;
   logic [7:0] held_data;
   logic       held_last;

   dpram_stream_reader #(
      .ADDR_W(10),
      .DATA_W(8)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .base_addr  (base_addr),
      .length     (length),
      .abort      (abort),
      .busy       (busy),
      .done       (done),
      .ram_address(ram_address),
      .ram_q      (ram_q),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered-read RAM port
   always @(posedge clk) ram_q <= mem[ram_address];

   // Stream monitor: pops the scoreboard on every transferring beat and checks
   // that a stalled word is held unchanged into the next cycle.
   always @(negedge clk) begin
      if (!reset_n) begin
         stall_pending = 1'b0;
      end else begin
         if (stall_pending) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== held_data || out_last !== held_last) begin
               failures++;
               $display("[TB] FAIL stall_hold: got valid=%b data=%h last=%b, need valid=1 data=%h last=%b",
                        out_valid, out_data, out_last, held_data, held_last);
            end
         end
         stall_pending = out_valid && !out_ready && !abort;
         held_data     = out_data;
         held_last     = out_last;
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            beats++;
            if (sb.size() == 0) begin
               failures++;
               $display("[TB] FAIL unexpected_beat: got data=%h last=%b, need no beat", out_data, out_last);
            end else begin
               automatic logic [8:0] exp = sb.pop_front();
               if ({out_last, out_data} !== exp) begin
                  failures++;
                  $display("[TB] FAIL beat: got data=%h last=%b, need data=%h last=%b",
                           out_data, out_last, exp[7:0], exp[8]);
               end
            end
         end
      end
   end

   // Issues one command and loads the scoreboard with the words it should produce.
   task automatic applyStimulus(input logic [9:0] base, input logic [9:0] len);
      @(posedge clk);
      #1;
      base_addr = base;
      length    = len;
      start     = 1'b1;
      for (int i = 0; i < int'(len); i++) begin
         automatic logic [9:0] a = base + 10'(i);
         sb.push_back({(i == int'(len) - 1), a[7:0] ^ 8'hA5});
      end
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Runs until done is seen at a falling edge or the budget expires.
   task automatic wait_done(input bit rnd, input int budget, output int cyc, output int vcyc);
      cyc  = 0;
      vcyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (out_valid === 1'b1) vcyc++;
         if (done === 1'b1 || cyc >= budget) break;
         @(posedge clk);
         #1;
         if (rnd) out_ready = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic test_reset;
      checks++;
      if ({busy, done, out_valid, out_last} !== 4'b0000) begin
         failures++;
         $display("[TB] FAIL reset_flags: got busy/done/valid/last=%b, need 0000",
                  {busy, done, out_valid, out_last});
      end
      checks++;
      if (ram_address !== 10'h000 || out_data !== 8'h00) begin
         failures++;
         $display("[TB] FAIL reset_values: got addr=%h data=%h, need 000/00", ram_address, out_data);
      end
   endtask

   task automatic test_basic;
      int cyc, vcyc, b0;
      b0 = beats;
      out_ready = 1'b1;
      applyStimulus(10'h010, 10'd4);
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL basic_after_start: got busy=%b valid=%b, need 1/0", busy, out_valid);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL basic_early_valid: got valid=%b, need 0", out_valid);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1) begin
         failures++;
         $display("[TB] FAIL basic_first_valid: got valid=%b, need 1", out_valid);
      end
      wait_done(1'b0, 50, cyc, vcyc);
      checks++;
      if (done !== 1'b1 || vcyc != 4 || cyc != 5) begin
         failures++;
         $display("[TB] FAIL basic_timing: got done=%b valid_cycles=%0d done_at=%0d, need 1/4/5",
                  done, vcyc, cyc);
      end
      checks++;
      if (busy !== 1'b0 || (beats - b0) != 4 || sb.size() != 0) begin
         failures++;
         $display("[TB] FAIL basic_end: got busy=%b beats=%0d left=%0d, need 0/4/0",
                  busy, beats - b0, sb.size());
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL basic_done_pulse: got done=%b, need 0", done);
      end
   endtask

   task automatic test_wrap;
      int cyc, vcyc, b0;
      b0 = beats;
      out_ready = 1'b1;
      applyStimulus(10'h3FE, 10'd4);
      wait_done(1'b0, 50, cyc, vcyc);
      checks++;
      if (done !== 1'b1 || (beats - b0) != 4 || sb.size() != 0) begin
         failures++;
         $display("[TB] FAIL wrap_count: got done=%b beats=%0d left=%0d, need 1/4/0",
                  done, beats - b0, sb.size());
      end
      checks++;
      if (ram_address !== 10'h002) begin
         failures++;
         $display("[TB] FAIL wrap_addr: got addr=%h, need 002", ram_address);
      end
   endtask

   task automatic test_backpressure;
      int cyc, vcyc, b0;
      b0 = beats;
      out_ready = 1'b0;
      applyStimulus(10'h123, 10'd8);
      wait_done(1'b1, 300, cyc, vcyc);
      out_ready = 1'b1;
      checks++;
      if (done !== 1'b1 || (beats - b0) != 8 || sb.size() != 0) begin
         failures++;
         $display("[TB] FAIL backpressure: got done=%b beats=%0d left=%0d, need 1/8/0",
                  done, beats - b0, sb.size());
      end
   endtask

   task automatic test_zero_length;
      logic seen;
      int   dones;
      seen  = 1'b0;
      dones = 0;
      out_ready = 1'b1;
      applyStimulus(10'h050, 10'd0);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL zero_done: got done=%b busy=%b, need 1/0", done, busy);
      end
      for (int i = 0; i < 6; i++) begin
         if (done === 1'b1) dones++;
         if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
         @(posedge clk);
         #1;
      end
      checks++;
      if (seen !== 1'b0 || dones != 1) begin
         failures++;
         $display("[TB] FAIL zero_quiet: got activity=%b done_pulses=%0d, need 0/1", seen, dones);
      end
   endtask

   task automatic test_abort;
      int cyc, vcyc, b0, n;
      b0 = beats;
      n  = 0;
      out_ready = 1'b1;
      applyStimulus(10'h200, 10'd16);
      while ((beats - b0) < 5 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      out_ready = 1'b0;
      abort     = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || n >= 100) begin
         failures++;
         $display("[TB] FAIL abort: got valid=%b done=%b busy=%b waited=%0d, need 0/1/0/<100",
                  out_valid, done, busy, n);
      end
      sb.delete();
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL abort_after: got done=%b valid=%b, need 0/0", done, out_valid);
      end
      out_ready = 1'b1;
      b0 = beats;
      applyStimulus(10'h000, 10'd2);
      wait_done(1'b0, 50, cyc, vcyc);
      checks++;
      if (done !== 1'b1 || (beats - b0) != 2 || sb.size() != 0) begin
         failures++;
         $display("[TB] FAIL abort_restart: got done=%b beats=%0d left=%0d, need 1/2/0",
                  done, beats - b0, sb.size());
      end
   endtask

   task automatic test_async_reset;
      int cyc, vcyc, b0;
      out_ready = 1'b1;
      applyStimulus(10'h080, 10'd16);
      repeat (4) @(posedge clk);
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, out_valid, out_last} !== 4'b0000 || ram_address !== 10'h000 || out_data !== 8'h00) begin
         failures++;
         $display("[TB] FAIL async_reset: got busy/done/valid/last=%b addr=%h data=%h, need 0000/000/00",
                  {busy, done, out_valid, out_last}, ram_address, out_data);
      end
      sb.delete();
      #12;
      reset_n = 1'b1;
      b0 = beats;
      applyStimulus(10'h020, 10'd3);
      wait_done(1'b0, 50, cyc, vcyc);
      checks++;
      if (done !== 1'b1 || (beats - b0) != 3 || sb.size() != 0) begin
         failures++;
         $display("[TB] FAIL reset_recover: got done=%b beats=%0d left=%0d, need 1/3/0",
                  done, beats - b0, sb.size());
      end
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      beats         = 0;
      stall_pending = 1'b0;
      held_data     = 8'h00;
      held_last     = 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'hA5;
      reset_n   = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      base_addr = '0;
      length    = '0;
      out_ready = 1'b1;
      #1;
      test_reset;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      test_basic;
      test_wrap;
      test_backpressure;
      test_zero_length;
      test_abort;
      test_async_reset;
      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
